// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit: FSM state
// encoding, buffer entry payload, instruction field positions, default reset
// PC and a word-alignment helper.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no request outstanding
        WAIT  = 2'd1,   // one request outstanding, response will be kept
        DRAIN = 2'd2    // one request outstanding, response will be dropped
    } fetch_state_e;

    localparam logic [XLEN-1:0] NOOP_INSTR       = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;

    // One fetch-buffer entry: returned word plus the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Clear the byte-offset bits of an address.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Synchronous FIFO of {instr, pc} entries between fetch and decode.
// flush empties the FIFO and overrides push and pop in the same cycle.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   push_i        : write push_data_i at the tail (ignored when full w/o pop)
//   push_data_i   : entry to write
//   pop_i         : drop the head entry (ignored when empty)
//   flush_i       : discard all entries
//   head_o        : current head entry (raw storage; qualify with empty_o)
//   count_o       : number of valid entries
//   full_o/empty_o: occupancy flags
// -----------------------------------------------------------------------------
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Entry storage; not reset, contents are qualified by the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: holds the PC, issues single-outstanding word requests to
// instruction memory, buffers returned words and hands them to decode with
// the Op/Funct fields. Redirects flush the buffer and any in-flight fetch.
// Optional build macro FETCH_PERF_CNT_EN adds FetchCount/FlushCount outputs.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   IMemReqValid/Ready/Addr     : request channel to instruction memory
//   IMemRespValid/Data          : response channel from instruction memory
//   InstrValid/Ready            : handshake of the buffer head to decode
//   Instr, InstrPC, PCPlus4     : head instruction, its PC and PC+4
//   Op, Funct                   : Instr[31:26], Instr[5:0]
//   Redirect, RedirectPC        : taken branch/jump and its target
//   FetchCount, FlushCount      : (FETCH_PERF_CNT_EN) consumed/flush counters
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        IMemReqValid,
    input  logic        IMemReqReady,
    output logic [31:0] IMemReqAddr,
    input  logic        IMemRespValid,
    input  logic [31:0] IMemRespData,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic [31:0] PCPlus4,
    output logic [5:0]  Op,
    output logic [5:0]  Funct,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] FlushCount
`endif
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             req_valid_c;
    logic             push_c;
    logic             pop_c;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;
    logic [CNT_W-1:0] buf_count;
    logic             buf_full;
    logic             buf_empty;

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_c),
        .push_data_i (push_entry),
        .pop_i       (pop_c),
        .flush_i     (Redirect),
        .head_o      (head),
        .count_o     (buf_count),
        .full_o      (buf_full),
        .empty_o     (buf_empty)
    );

    assign push_entry = '{instr: IMemRespData, pc: req_pc_q};
    assign pop_c      = InstrValid && InstrReady;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    // Next state, request issue and buffer push; Redirect has top priority.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        req_valid_c = 1'b0;
        push_c      = 1'b0;

        if (Redirect) begin
            fetch_pc_d = word_align(RedirectPC);
        end

        case (state_q)
            IDLE: begin
                // No request outstanding, so buffer space is the only limit.
                req_valid_c = !reset && !Redirect && (buf_count < CNT_W'(BUF_DEPTH));
                if (req_valid_c && IMemReqReady) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (Redirect) begin
                    state_d = IMemRespValid ? IDLE : DRAIN;
                end else if (IMemRespValid) begin
                    push_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (IMemRespValid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Occupancy plus the outstanding request never exceeds the depth.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (state_q != IDLE) |-> !buf_full);

    assign IMemReqValid = req_valid_c;
    assign IMemReqAddr  = fetch_pc_q;

    // Decode-side view of the buffer head; zeroed while empty.
    assign InstrValid = !buf_empty;
    assign Instr      = buf_empty ? NOOP_INSTR : head.instr;
    assign InstrPC    = buf_empty ? 32'h0      : head.pc;
    assign PCPlus4    = buf_empty ? 32'h0      : head.pc + 32'd4;
    assign Op         = Instr[OP_MSB:OP_LSB];
    assign Funct      = Instr[FUNCT_MSB:FUNCT_LSB];

`ifdef FETCH_PERF_CNT_EN
    // Consumed-instruction and redirect counters, free-running with wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            FetchCount <= '0;
            FlushCount <= '0;
        end else begin
            if (pop_c) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (Redirect) begin
                FlushCount <= FlushCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit with a queue-based reference model and a
// variable-latency instruction memory whose data is a function of the address.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        IMemReqValid;
    logic        IMemReqReady;
    logic [31:0] IMemReqAddr;
    logic        IMemRespValid;
    logic [31:0] IMemRespData;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic [31:0] PCPlus4;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        Redirect;
    logic [31:0] RedirectPC;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount;
    logic [31:0] FlushCount;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .IMemReqValid  (IMemReqValid),
        .IMemReqReady  (IMemReqReady),
        .IMemReqAddr   (IMemReqAddr),
        .IMemRespValid (IMemRespValid),
        .IMemRespData  (IMemRespData),
        .InstrValid    (InstrValid),
        .InstrReady    (InstrReady),
        .Instr         (Instr),
        .InstrPC       (InstrPC),
        .PCPlus4       (PCPlus4),
        .Op            (Op),
        .Funct         (Funct),
        .Redirect      (Redirect),
        .RedirectPC    (RedirectPC)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount    (FetchCount),
        .FlushCount    (FlushCount)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: buffered PCs in fetch order plus outstanding-fetch flags.
    logic [31:0] q_pc[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_req_pc;
    bit          m_busy;
    bit          m_discard;
    logic [31:0] m_fetch_cnt;
    logic [31:0] m_flush_cnt;

    // Memory: pend = cycles until the response (0 = this cycle, -1 = none).
    int          pend;
    logic [31:0] pend_addr;
    int          resp_delay;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h8C41_0004;
    endfunction

    function automatic bit m_req_valid();
        return !reset && !m_busy && (q_pc.size() < int'(DEPTH)) && !Redirect;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // First half of a cycle: present the memory response, compare to model.
    task automatic step_a();
        logic [31:0] e;
        @(negedge clk);
        IMemRespValid = (pend == 0);
        IMemRespData  = (pend == 0) ? mdata(pend_addr) : 32'h0;
        #1;
        check("IMemReqValid", 32'(IMemReqValid), 32'(m_req_valid()));
        check("IMemReqAddr", IMemReqAddr, m_fetch_pc);
        if (q_pc.size() > 0) begin
            e = mdata(q_pc[0]);
            check("InstrValid", 32'(InstrValid), 32'd1);
            check("Instr", Instr, e);
            check("InstrPC", InstrPC, q_pc[0]);
            check("PCPlus4", PCPlus4, q_pc[0] + 32'd4);
            check("Op", 32'(Op), 32'(e[31:26]));
            check("Funct", 32'(Funct), 32'(e[5:0]));
        end else begin
            check("InstrValid", 32'(InstrValid), 32'd0);
            check("Instr", Instr, 32'h0);
            check("InstrPC", InstrPC, 32'h0);
        end
`ifdef FETCH_PERF_CNT_EN
        check("FetchCount", FetchCount, m_fetch_cnt);
        check("FlushCount", FlushCount, m_flush_cnt);
`endif
    endtask

    // Second half: advance memory and model, then cross the rising edge.
    task automatic step_b();
        bit hs_model;
        bit pop;
        bit resp;
        resp     = IMemRespValid;
        hs_model = m_req_valid() && IMemReqReady;
        pop      = (q_pc.size() > 0) && InstrReady;

        if (pend >= 0) pend--;
        if (IMemReqValid && IMemReqReady) begin
            pend      = resp_delay - 1;
            pend_addr = IMemReqAddr;
        end

        if (reset) begin
            q_pc.delete();
            m_fetch_pc  = RST_PC;
            m_busy      = 0;
            m_discard   = 0;
            m_fetch_cnt = 32'h0;
            m_flush_cnt = 32'h0;
        end else begin
            if (pop) m_fetch_cnt++;
            if (Redirect) begin
                m_flush_cnt++;
                q_pc.delete();
                m_fetch_pc = {RedirectPC[31:2], 2'b00};
                if (m_busy && !resp) begin
                    m_discard = 1;
                end else begin
                    m_busy    = 0;
                    m_discard = 0;
                end
            end else begin
                if (pop) void'(q_pc.pop_front());
                if (m_busy && resp) begin
                    if (!m_discard) q_pc.push_back(m_req_pc);
                    m_busy    = 0;
                    m_discard = 0;
                end else if (hs_model) begin
                    m_busy     = 1;
                    m_req_pc   = m_fetch_pc;
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        step_a();
        step_b();
    endtask

    logic [39:0] rdy_pat;
    logic [39:0] take_pat;

    initial begin
        reset         = 1'b1;
        IMemReqReady  = 1'b0;
        IMemRespValid = 1'b0;
        IMemRespData  = 32'h0;
        InstrReady    = 1'b0;
        Redirect      = 1'b0;
        RedirectPC    = 32'h0;
        pend          = -1;
        pend_addr     = 32'h0;
        resp_delay    = 1;
        m_fetch_pc    = RST_PC;
        m_req_pc      = 32'h0;
        m_busy        = 0;
        m_discard     = 0;
        m_fetch_cnt   = 32'h0;
        m_flush_cnt   = 32'h0;
        @(posedge clk);
        #1;

        // Reset state.
        step_a();
        check("rst_req_valid", 32'(IMemReqValid), 32'd0);
        check("rst_addr", IMemReqAddr, RST_PC);
        check("rst_instr_valid", 32'(InstrValid), 32'd0);
        step_b();
        cycle();

        // First fetch latency and field extraction; decode stalled.
        reset        = 1'b0;
        IMemReqReady = 1'b1;
        step_a();
        check("t1_addr0", IMemReqAddr, 32'h0);
        check("t1_req_valid", 32'(IMemReqValid), 32'd1);
        step_b();
        cycle();
        step_a();
        check("t1_valid", 32'(InstrValid), 32'd1);
        check("t1_instr", Instr, 32'h8C41_0004);
        check("t1_pc", InstrPC, 32'h0);
        check("t1_pcplus4", PCPlus4, 32'h4);
        check("t1_op", 32'(Op), 32'(6'b100011));
        check("t1_funct", 32'(Funct), 32'(6'b000100));
        step_b();
        repeat (7) cycle();

        // Buffer full: no request; first pop re-enables fetch of PC 8.
        InstrReady = 1'b1;
        step_a();
        check("t2_full_head", InstrPC, 32'h0);
        check("t2_full_noreq", 32'(IMemReqValid), 32'd0);
        step_b();
        InstrReady = 1'b0;
        resp_delay = 3;
        step_a();
        check("t2_reassert", 32'(IMemReqValid), 32'd1);
        check("t2_next_addr", IMemReqAddr, 32'h8);
        check("t2_head", InstrPC, 32'h4);
        step_b();

        // Redirect while waiting on a slow response.
        resp_delay = 1;
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_0103;
        cycle();
        Redirect = 1'b0;
        cycle();
        step_a();
        check("t3_drain_noreq", 32'(IMemReqValid), 32'd0);
        check("t3_flushed", 32'(InstrValid), 32'd0);
        step_b();
        step_a();
        check("t3_addr", IMemReqAddr, 32'h0000_0100);
        check("t3_req_valid", 32'(IMemReqValid), 32'd1);
        check("t3_empty", 32'(InstrValid), 32'd0);
        step_b();

        // Redirect coincident with a response and a pop.
        cycle();
        cycle();
        InstrReady = 1'b1;
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_0200;
        step_a();
        check("t4_head", InstrPC, 32'h0000_0100);
        check("t4_resp", 32'(IMemRespValid), 32'd1);
        step_b();
        InstrReady = 1'b0;
        Redirect   = 1'b0;
        step_a();
        check("t4_no_push", 32'(InstrValid), 32'd0);
        check("t4_addr", IMemReqAddr, 32'h0000_0200);
`ifdef FETCH_PERF_CNT_EN
        check("t4_fetch_cnt", FetchCount, 32'd2);
        check("t4_flush_cnt", FlushCount, 32'd2);
`endif
        step_b();

        // Redirect in IDLE suppresses the request; then PC wraps.
        cycle();
        Redirect   = 1'b1;
        RedirectPC = 32'hFFFF_FFFC;
        step_a();
        check("t5_idle_noreq", 32'(IMemReqValid), 32'd0);
        check("t5_head", InstrPC, 32'h0000_0200);
        step_b();
        Redirect = 1'b0;
        step_a();
        check("t5_addr_top", IMemReqAddr, 32'hFFFF_FFFC);
        step_b();
        cycle();
        step_a();
        check("t5_head_pc", InstrPC, 32'hFFFF_FFFC);
        check("t5_pcplus4", PCPlus4, 32'h0);
        check("t5_addr_wrap", IMemReqAddr, 32'h0);
        step_b();

        // Reset while waiting, with the response landing in the reset cycle.
        reset = 1'b1;
        step_a();
        check("t6_resp", 32'(IMemRespValid), 32'd1);
        step_b();
        reset = 1'b0;
        step_a();
        check("t6_no_push", 32'(InstrValid), 32'd0);
        check("t6_addr", IMemReqAddr, RST_PC);
        check("t6_req_valid", 32'(IMemReqValid), 32'd1);
        step_b();

        // Mixed backpressure, latencies and redirects.
        rdy_pat  = 40'hB7_3D_E9_5F_6B;
        take_pat = 40'h5A_C3_F0_9E_27;
        for (int i = 0; i < 40; i++) begin
            IMemReqReady = rdy_pat[i];
            InstrReady   = take_pat[i];
            resp_delay   = 1 + (i % 3);
            Redirect     = (i == 13) || (i == 22) || (i == 23) || (i == 31);
            RedirectPC   = 32'h0000_0400 + 32'(i * 6);
            cycle();
        end
        Redirect     = 1'b0;
        IMemReqReady = 1'b1;
        InstrReady   = 1'b1;
        repeat (6) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the control unit and decoder.
- Holds the PC and issues word requests to instruction memory over a valid/ready request channel with a separate response channel.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake, together with the Op/Funct fields.
- Branch/jump redirects flush the buffer and any in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0).
- BUF_DEPTH, 2, fetch-buffer entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- IMemReqValid  out  1  fetch request valid.
- IMemReqReady  in  1  memory accepts request this cycle.
- IMemReqAddr  out  32  word-aligned fetch address.
- IMemRespValid  in  1  instruction word returned this cycle.
- IMemRespData  in  32  returned instruction.
- InstrValid  out  1  buffer head valid.
- InstrReady  in  1  decode consumes head this cycle.
- Instr  out  32  head instruction; 32'h0000_0000 when empty.
- InstrPC  out  32  PC of head instruction.
- PCPlus4  out  32  InstrPC + 4, mod 2^32.
- Op  out  6  Instr[31:26].
- Funct  out  6  Instr[5:0].
- Redirect  in  1  taken branch/jump; flush and refetch.
- RedirectPC  in  32  new fetch PC; bits [1:0] ignored (treated as 0).

Behaviour:
- Reset (synchronous, active-high) sets:
  - state=IDLE, FetchPC=RESET_PC, buffer count=0.
  - All outputs 0 except IMemReqAddr=RESET_PC.
  - Reset mid-fetch abandons the outstanding request. A response arriving in the reset cycle is ignored.
- FSM states:
  - IDLE: no request outstanding.
    - IMemReqValid = (count<BUF_DEPTH) && !Redirect.
    - On Valid&&Ready: latch ReqPC=FetchPC, FetchPC+=4, go to WAIT.
  - WAIT: one request outstanding, IMemReqValid=0.
    - On IMemRespValid: push {IMemRespData, ReqPC} and go to IDLE.
  - DRAIN: outstanding response must be discarded, IMemReqValid=0.
    - On IMemRespValid: drop the data and go to IDLE.
- At most one outstanding request. count + outstanding ≤ BUF_DEPTH always holds, so a push never overflows.
- IMemReqAddr = FetchPC (combinational from the register).
- Latency with Ready=1 and a 1-cycle memory:
  - Request in cycle N, response in N+1, InstrValid in N+2.
  - Steady-state throughput is 1 instruction per 2 cycles.
- Buffer:
  - FIFO ordered by fetch order.
  - Pop on InstrValid&&InstrReady.
  - Simultaneous push and pop leaves count unchanged.
  - Empty: InstrValid=0, Instr=0, InstrPC=0.
- Redirect (highest priority):
  - Flushes the buffer (count=0). A pop in the same cycle counts as consumed.
  - FetchPC <= {RedirectPC[31:2],2'b00}.
  - Next state by current state:
    - IDLE → IDLE; no request is issued that cycle.
    - WAIT without a response that cycle → DRAIN.
    - WAIT with a response that cycle → response discarded, → IDLE.
    - DRAIN → DRAIN, or IDLE if the response arrives that cycle.
  - Back-to-back redirects: the last one wins.
- PC arithmetic: 32-bit unsigned, wraps 32'hFFFF_FFFC → 32'h0000_0000.
- IMemRespValid outside WAIT/DRAIN is ignored.

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds output ports FetchCount[31:0] and FlushCount[31:0].
  - FetchCount increments on InstrValid&&InstrReady.
  - FlushCount increments on each Redirect cycle.
  - Both reset to 0 and wrap at 2^32.
- Macro undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, DRAIN=2'd2).
  - NOOP_INSTR=32'h0000_0000.
  - OP_MSB/OP_LSB=31/26, FUNCT_MSB/FUNCT_LSB=5/0.
  - Default RESET_PC.
- One sub-module, fetch_buffer: synchronous FIFO of {instr,pc} entries.
  - Parameter: depth.
  - Ports: push, pop, flush, count/full/empty.
  - flush overrides push and pop.

Test Plan:
- Reset release, Ready=1, memory returns 32'h8C41_0004 one cycle after each request → IMemReqAddr=0 in cycle 0; InstrValid in cycle 2 with Instr=32'h8C41_0004, InstrPC=0, PCPlus4=4, Op=6'b100011, Funct=6'b000100.
- InstrReady=0 for 10 cycles → exactly BUF_DEPTH=2 entries buffered (PCs 0,4). IMemReqValid stays 0 while full and reasserts the cycle after the first pop.
- Redirect to RedirectPC=32'h0000_0103 while in WAIT with the response delayed 3 cycles → response dropped, buffer empty; the next request address is 32'h0000_0100.
- Redirect in the same cycle as IMemRespValid and InstrValid&&InstrReady → no push, count=0; the next request uses the redirect PC; with FETCH_PERF_CNT_EN, FetchCount+1 and FlushCount+1.
- RedirectPC=32'hFFFF_FFFC → requests to FFFF_FFFC, then 0000_0000; the FFFF_FFFC entry has PCPlus4=0.
- Reset asserted while in WAIT and the response arrives in the reset cycle → no push; the next request address is RESET_PC.
